alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Two-port request scheduler that time-shares the single 24-bit combinational ALU between the scalar pipeline (port 0) and the vector/coprocessor path (port 1). Each port sends operands and a 3-bit ALU opcode through a valid/ready handshake. The block arbitrates, registers the winner's operands onto the ALU inputs, and captures result and flags one cycle later. It returns them on a per-port response channel with its own valid/ready handshake, so neither requester ever drives the ALU directly.

## Interface
- N, 24, datapath width; must match the ALU instance width.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid, req1_valid  in  1  request present on port 0 / 1.
- req0_ready, req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b, req1_a, req1_b  in  N  operands.
- req0_op, req1_op  in  3  ALU opcode:
  - 0 add, 1 xor, 2 sub, 3 slt, 4 sll, 5 srl, 6 mult.
  - 7 is illegal.
- alu_a, alu_b  out  N  registered drive to ALU operand inputs.
- alu_ctrl  out  3  registered drive to ALU control.
- alu_result  in  N  ALU result.
- alu_flags  in  5  {CarryOut, zero, gt, overflow, negative} from the ALU.
- rsp0_valid, rsp1_valid  out  1  response available.
- rsp0_ready, rsp1_ready  in  1  consumer accepts response.
- rsp0_result, rsp1_result  out  N  captured result.
- rsp0_flags, rsp1_flags  out  5  captured flags, same bit order as alu_flags.
- rsp0_err, rsp1_err  out  1  request carried illegal opcode 7.

## Operation
- FSM states IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any reqX_valid is high, pick the winner and raise its reqX_ready combinationally. The loser's ready stays 0.
  - On that edge, latch a/b/op into alu_a/alu_b/alu_ctrl and record the grant. Go to EXEC.
  - No valid: stay in IDLE, all ready 0.
- EXEC:
  - The ALU settles from the registered inputs.
  - On the edge, capture alu_result/alu_flags into the granted port's response registers and set rspX_valid=1. Go to RESP.
  - Opcode 7: do not capture. Load result 0, flags 0, rspX_err=1.
  - alu_ctrl is still driven with 7. The ALU output is don't-care.
- RESP:
  - Hold rspX_valid and data stable until rspX_ready=1.
  - On the handshake edge: clear rspX_valid and rspX_err, then go to IDLE.
- Only one operation is in flight at a time. No request is accepted in EXEC or RESP.
- Arbitration when both ports are valid in IDLE follows the Configuration section. A single valid requester always wins.
- alu_a/alu_b/alu_ctrl hold their last values outside a grant. They change only on an accept edge.
- rspX_result/flags hold their last captured value after the handshake.
- The unused port's response outputs never change.

## Timing
- Reset values:
  - all ready 0, all rsp*_valid 0, rsp*_err 0.
  - rsp*_result 0, rsp*_flags 0.
  - alu_a 0, alu_b 0, alu_ctrl 0.
  - last_grant=1, so port 0 wins the first tie.
- Accept at edge T; rspX_valid=1 after edge T+2.
- With rspX_ready held high, the handshake completes at edge T+3. The next accept is earliest at edge T+3 (IDLE in cycle T+3, accept on edge T+4 if it is the same cycle). Peak throughput is one op per 3 cycles.
- reqX_ready depends combinationally on req0_valid/req1_valid and state. It has no path from rsp*_ready.
- rst asserted in any state returns to IDLE on that edge with reset values:
  - the in-flight response is discarded;
  - no rsp_valid pulse occurs.
- A requester dropping valid without ready is legal. Nothing is latched.

## Configuration
- ALU_SHARE_RR_EN defined: round-robin on ties.
  - The port not equal to last_grant wins.
  - last_grant updates on every accept.
- Not defined: fixed priority. Port 0 always wins ties and last_grant is unused. Port 1 can starve under continuous port 0 traffic.

## Test plan
- Port 0 add, a=0x000005, b=0x000003, rsp0_ready=1:
  - req0_ready pulses at T;
  - rsp0_valid at T+2 with result 0x000008, flags 0.
- Port 1 sub, a=0x000003, b=0x000005:
  - rsp1_result 0xFFFFFE, negative=1, gt=0;
  - port 0 outputs unchanged.
- Both valid continuously:
  - with ALU_SHARE_RR_EN, grants alternate 0,1,0,1;
  - without it, four consecutive grants go to port 0 and rsp1_valid never rises.
- Back-pressure: hold rsp0_ready=0 for 5 cycles.
  - rsp0_valid and data stay stable;
  - req1_ready stays 0 throughout;
  - port 1 is accepted on the cycle after the rsp0 handshake.
- Port 0 op=7: rsp0_err=1, result 0, flags 0 at T+2; err clears after the handshake.
- rst asserted during EXEC:
  - next cycle IDLE;
  - all rsp_valid 0, alu_a/alu_b/alu_ctrl = 0;
  - no response is delivered for the aborted request.

Source files
------------

// File: rtl/alu_share_if.sv
// ----------------------------------------------------------------------------
// alu_share_if
// Request/response bundle between the two ALU requesters and alu_share_ctrl.
//   req0_* / req1_* : valid/ready request channel carrying a, b and a 3-bit op
//   rsp0_* / rsp1_* : valid/ready response channel returning result, flags
//                     ({carry, zero, gt, overflow, negative}) and err
// Modports:
//   master : the requester side (scalar pipeline, vector path or a bench)
//   slave  : the scheduler side (alu_share_ctrl)
// ----------------------------------------------------------------------------
interface alu_share_if #(
   parameter int N = 24
);
   logic         req0_valid;
   logic         req0_ready;
   logic [N-1:0] req0_a;
   logic [N-1:0] req0_b;
   logic [2:0]   req0_op;

   logic         req1_valid;
   logic         req1_ready;
   logic [N-1:0] req1_a;
   logic [N-1:0] req1_b;
   logic [2:0]   req1_op;

   logic         rsp0_valid;
   logic         rsp0_ready;
   logic [N-1:0] rsp0_result;
   logic [4:0]   rsp0_flags;
   logic         rsp0_err;

   logic         rsp1_valid;
   logic         rsp1_ready;
   logic [N-1:0] rsp1_result;
   logic [4:0]   rsp1_flags;
   logic         rsp1_err;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output rsp0_ready, rsp1_ready,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_result, rsp0_flags, rsp0_err,
      input  rsp1_valid, rsp1_result, rsp1_flags, rsp1_err
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  rsp0_ready, rsp1_ready,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_result, rsp0_flags, rsp0_err,
      output rsp1_valid, rsp1_result, rsp1_flags, rsp1_err
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl
// Time-shares one combinational N-bit ALU between port 0 (scalar pipeline)
// and port 1 (vector/coprocessor path). One operation is in flight at a time:
// IDLE accepts a request and registers its operands onto the ALU inputs, EXEC
// captures the ALU result/flags into the granted port's response registers,
// RESP holds the response until the consumer takes it.
//
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous, active-high reset
//   bus        : alu_share_if.slave, both request and response channels
//   alu_a/b    : registered ALU operand drive
//   alu_ctrl   : registered ALU opcode drive (7 = illegal, still driven)
//   alu_result : ALU result input
//   alu_flags  : ALU flags input {carry, zero, gt, overflow, negative}
//
// Build option:
//   ALU_SHARE_RR_EN defined   -> round-robin between ports on a tie
//   ALU_SHARE_RR_EN undefined -> port 0 always wins a tie
// ----------------------------------------------------------------------------
module alu_share_ctrl #(
   parameter int N = 24
) (
   input  logic         clk,
   input  logic         rst,
   alu_share_if.slave   bus,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [2:0]   alu_ctrl,
   input  logic [N-1:0] alu_result,
   input  logic [4:0]   alu_flags
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   localparam logic [2:0] OP_ILLEGAL = 3'd7;

   state_t state;
   logic   gnt;       // port being served: 0 or 1
   logic   pick1;     // port 1 wins arbitration this cycle
   logic   illegal;

`ifdef ALU_SHARE_RR_EN
   logic last_grant;

   // On a tie the port that was not served last wins.
   assign pick1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
`else
   // Fixed priority: port 1 only wins when port 0 is idle.
   assign pick1 = bus.req1_valid && !bus.req0_valid;
`endif

   // NOTE: the readies are continuous assigns of state and request valids
   // only, so they can never become latches and have no path from rsp*_ready.
   assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !pick1;
   assign bus.req1_ready = (state == IDLE) && pick1;

   assign illegal = (alu_ctrl == OP_ILLEGAL);

   // NOTE: all state below is updated with non-blocking assignments so every
   // register samples the values from before the edge, regardless of order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         gnt             <= 1'b0;
`ifdef ALU_SHARE_RR_EN
         last_grant      <= 1'b1;
`endif
         alu_a           <= '0;
         alu_b           <= '0;
         alu_ctrl        <= '0;
         bus.rsp0_valid  <= 1'b0;
         bus.rsp0_result <= '0;
         bus.rsp0_flags  <= '0;
         bus.rsp0_err    <= 1'b0;
         bus.rsp1_valid  <= 1'b0;
         bus.rsp1_result <= '0;
         bus.rsp1_flags  <= '0;
         bus.rsp1_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req0_valid || bus.req1_valid) begin
                  alu_a    <= pick1 ? bus.req1_a  : bus.req0_a;
                  alu_b    <= pick1 ? bus.req1_b  : bus.req0_b;
                  alu_ctrl <= pick1 ? bus.req1_op : bus.req0_op;
                  gnt      <= pick1;
`ifdef ALU_SHARE_RR_EN
                  last_grant <= pick1;
`endif
                  state    <= EXEC;
               end
            end

            EXEC: begin
               // An illegal opcode reports a clean zero result with err set;
               // whatever the ALU produced for it is ignored.
               if (!gnt) begin
                  bus.rsp0_valid  <= 1'b1;
                  bus.rsp0_result <= illegal ? '0 : alu_result;
                  bus.rsp0_flags  <= illegal ? '0 : alu_flags;
                  bus.rsp0_err    <= illegal;
               end else begin
                  bus.rsp1_valid  <= 1'b1;
                  bus.rsp1_result <= illegal ? '0 : alu_result;
                  bus.rsp1_flags  <= illegal ? '0 : alu_flags;
                  bus.rsp1_err    <= illegal;
               end
               state <= RESP;
            end

            RESP: begin
               // Result and flags are left in place after the handshake.
               if (gnt ? bus.rsp1_ready : bus.rsp0_ready) begin
                  bus.rsp0_valid <= 1'b0;
                  bus.rsp0_err   <= 1'b0;
                  bus.rsp1_valid <= 1'b0;
                  bus.rsp1_err   <= 1'b0;
                  state          <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_share_ctrl
// Self-checking bench for alu_share_ctrl. A behavioural 24-bit ALU sits on the
// alu_* ports. Accepted requests push their hand-computed expected response
// into a per-port queue; per-port monitors pop and compare on each response
// handshake and check that held responses stay stable. Directed sequences
// cover latency, illegal opcode, back-pressure, tie arbitration and reset.
// ----------------------------------------------------------------------------
module tb_alu_share_ctrl;
   localparam int N = 24;

   typedef struct packed {
      logic [N-1:0] r;
      logic [4:0]   f;
      logic         e;
   } exp_t;

   typedef struct {
      int           port;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [2:0]   op;
      exp_t         e;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] alu_a, alu_b, alu_result;
   logic [2:0]   alu_ctrl;
   logic [4:0]   alu_flags;

   always #5 clk = ~clk;

   alu_share_if #(.N(N)) bus ();

   alu_share_ctrl #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .alu_flags  (alu_flags)
   );

   // Behavioural ALU; opcode 7 yields junk so a leak into the response shows.
   logic [N:0]   wide;
   logic [N-1:0] r;
   logic         c, gt, ov;
   always_comb begin
      wide = '0; r = '0; c = 1'b0; gt = 1'b0; ov = 1'b0;
      case (alu_ctrl)
         3'd0: begin
            wide = {1'b0, alu_a} + {1'b0, alu_b};
            r = wide[N-1:0]; c = wide[N];
            ov = (alu_a[N-1] == alu_b[N-1]) && (r[N-1] != alu_a[N-1]);
         end
         3'd1: r = alu_a ^ alu_b;
         3'd2: begin
            wide = {1'b0, alu_a} + {1'b0, ~alu_b} + 25'd1;
            r = wide[N-1:0]; c = wide[N];
            ov = (alu_a[N-1] != alu_b[N-1]) && (r[N-1] != alu_a[N-1]);
            gt = $signed(alu_a) > $signed(alu_b);
         end
         3'd3: begin
            r  = ($signed(alu_a) < $signed(alu_b)) ? 24'd1 : 24'd0;
            gt = $signed(alu_a) > $signed(alu_b);
         end
         3'd4: r = alu_a << alu_b[4:0];
         3'd5: r = alu_a >> alu_b[4:0];
         3'd6: r = alu_a * alu_b;
         default: r = 24'h00DEAD;
      endcase
      alu_result = r;
      alu_flags  = (alu_ctrl == 3'd7) ? 5'b11111 : {c, (r == '0), gt, ov, r[N-1]};
   end

   int   vec_cnt = 0;
   int   err_cnt = 0;
   int   cyc = 0;
   exp_t q0[$], q1[$];
   exp_t exp_cur0, exp_cur1;
   int   gq[$];
   bit   rsp0_seen, rsp1_seen;
   bit   p0_hold, p1_hold;
   logic [31:0] p0_snap, p1_snap;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard push on accept, pop/compare on response handshake.
   always @(negedge clk) begin
      if (rst) begin
         p0_hold = 1'b0;
         p1_hold = 1'b0;
      end else begin
         if (bus.req0_ready) begin q0.push_back(exp_cur0); gq.push_back(0); end
         if (bus.req1_ready) begin q1.push_back(exp_cur1); gq.push_back(1); end
         if (bus.rsp0_valid) rsp0_seen = 1'b1;
         if (bus.rsp1_valid) rsp1_seen = 1'b1;

         if (p0_hold)
            check("rsp0 held stable", {1'b0, bus.rsp0_valid, bus.rsp0_result, bus.rsp0_flags, bus.rsp0_err}, p0_snap);
         if (p1_hold)
            check("rsp1 held stable", {1'b0, bus.rsp1_valid, bus.rsp1_result, bus.rsp1_flags, bus.rsp1_err}, p1_snap);

         if (bus.rsp0_valid && bus.rsp0_ready) begin
            check("rsp0 expected pending", q0.size() > 0, 1);
            if (q0.size() > 0) begin
               exp_t e;
               e = q0.pop_front();
               check("rsp0 result", bus.rsp0_result, e.r);
               check("rsp0 flags", bus.rsp0_flags, e.f);
               check("rsp0 err", bus.rsp0_err, e.e);
            end
         end
         if (bus.rsp1_valid && bus.rsp1_ready) begin
            check("rsp1 expected pending", q1.size() > 0, 1);
            if (q1.size() > 0) begin
               exp_t e;
               e = q1.pop_front();
               check("rsp1 result", bus.rsp1_result, e.r);
               check("rsp1 flags", bus.rsp1_flags, e.f);
               check("rsp1 err", bus.rsp1_err, e.e);
            end
         end

         p0_hold = bus.rsp0_valid && !bus.rsp0_ready;
         p0_snap = {1'b0, bus.rsp0_valid, bus.rsp0_result, bus.rsp0_flags, bus.rsp0_err};
         p1_hold = bus.rsp1_valid && !bus.rsp1_ready;
         p1_snap = {1'b0, bus.rsp1_valid, bus.rsp1_result, bus.rsp1_flags, bus.rsp1_err};
      end
   end

   // Present one request, return the cycle it was accepted (-1 on timeout).
   task automatic send(input int port, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2:0] op, input exp_t e, output int acc);
      @(posedge clk); #1;
      if (port == 0) begin
         exp_cur0 = e; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
      end else begin
         exp_cur1 = e; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
      end
      acc = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((port == 0 && bus.req0_ready) || (port == 1 && bus.req1_ready)) begin
            acc = cyc;
            break;
         end
      end
      check($sformatf("port%0d accepted", port), acc >= 0, 1);
      @(posedge clk); #1;
      if (port == 0) bus.req0_valid = 1'b0;
      else           bus.req1_valid = 1'b0;
   endtask

   // Wait for the port's response to appear, return its cycle (-1 on timeout).
   task automatic wait_rsp(input int port, output int rcyc);
      rcyc = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((port == 0 && bus.rsp0_valid) || (port == 1 && bus.rsp1_valid)) begin
            rcyc = cyc;
            break;
         end
      end
      check($sformatf("port%0d response arrived", port), rcyc >= 0, 1);
   endtask

   vec_t vt[7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          c, rr, held;
      logic [31:0] snap;
      int          exp_g[4];

      rst = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
      exp_cur0 = '0; exp_cur1 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("reset req0_ready", bus.req0_ready, 0);
      check("reset req1_ready", bus.req1_ready, 0);
      check("reset rsp0_valid", bus.rsp0_valid, 0);
      check("reset rsp1_valid", bus.rsp1_valid, 0);
      check("reset rsp0_err", bus.rsp0_err, 0);
      check("reset rsp1_err", bus.rsp1_err, 0);
      check("reset rsp0_result", bus.rsp0_result, 0);
      check("reset rsp1_flags", bus.rsp1_flags, 0);
      check("reset alu_a", alu_a, 0);
      check("reset alu_b", alu_b, 0);
      check("reset alu_ctrl", alu_ctrl, 0);

      // Port 0 add 5+3, two-cycle latency, port 1 untouched
      snap = {1'b0, bus.rsp1_valid, bus.rsp1_result, bus.rsp1_flags, bus.rsp1_err};
      send(0, 24'h000005, 24'h000003, 3'd0, {24'h000008, 5'b00000, 1'b0}, c);
      @(negedge clk);
      check("req0_ready single pulse", bus.req0_ready, 0);
      wait_rsp(0, rr);
      check("port0 add latency", rr - c, 2);
      check("port1 outputs unchanged", {1'b0, bus.rsp1_valid, bus.rsp1_result, bus.rsp1_flags, bus.rsp1_err}, snap);

      // Port 1 sub 3-5, port 0 untouched
      @(negedge clk);
      snap = {1'b0, bus.rsp0_valid, bus.rsp0_result, bus.rsp0_flags, bus.rsp0_err};
      send(1, 24'h000003, 24'h000005, 3'd2, {24'hFFFFFE, 5'b00001, 1'b0}, c);
      wait_rsp(1, rr);
      check("port1 sub latency", rr - c, 2);
      check("port0 outputs unchanged", {1'b0, bus.rsp0_valid, bus.rsp0_result, bus.rsp0_flags, bus.rsp0_err}, snap);

      // Illegal opcode on port 0
      send(0, 24'h000001, 24'h000002, 3'd7, {24'h000000, 5'b00000, 1'b1}, c);
      wait_rsp(0, rr);
      check("port0 illegal latency", rr - c, 2);
      @(negedge clk);
      check("rsp0_err cleared", bus.rsp0_err, 0);
      check("rsp0_valid cleared", bus.rsp0_valid, 0);

      // Directed opcode vectors
      vt[0] = '{0, 24'h000005, 24'h000005, 3'd2, {24'h000000, 5'b11000, 1'b0}};
      vt[1] = '{1, 24'h800000, 24'h000001, 3'd3, {24'h000001, 5'b00000, 1'b0}};
      vt[2] = '{0, 24'h000001, 24'h000004, 3'd4, {24'h000010, 5'b00000, 1'b0}};
      vt[3] = '{1, 24'h800000, 24'h000017, 3'd5, {24'h000001, 5'b00000, 1'b0}};
      vt[4] = '{0, 24'h001000, 24'h001000, 3'd6, {24'h000000, 5'b01000, 1'b0}};
      vt[5] = '{1, 24'h7FFFFF, 24'h000001, 3'd0, {24'h800000, 5'b00011, 1'b0}};
      vt[6] = '{0, 24'hFFFFFF, 24'h000001, 3'd0, {24'h000000, 5'b11000, 1'b0}};
      foreach (vt[i]) begin
         send(vt[i].port, vt[i].a, vt[i].b, vt[i].op, vt[i].e, c);
         wait_rsp(vt[i].port, rr);
      end

      // Back-pressure on port 0 with port 1 waiting
      @(negedge clk);
      bus.rsp0_ready = 1'b0;
      send(0, 24'h123456, 24'h00FF00, 3'd1, {24'h12CB56, 5'b00000, 1'b0}, c);
      exp_cur1 = {24'h000004, 5'b00000, 1'b0};
      bus.req1_a = 24'h000002; bus.req1_b = 24'h000002; bus.req1_op = 3'd0;
      bus.req1_valid = 1'b1;
      held = 0;
      for (int i = 0; i < 40 && held < 5; i++) begin
         @(negedge clk);
         check("req1_ready blocked", bus.req1_ready, 0);
         if (bus.rsp0_valid) held++;
      end
      check("rsp0 held cycles", held, 5);
      @(posedge clk); #1 bus.rsp0_ready = 1'b1;
      @(negedge clk);
      check("req1_ready blocked at handshake", bus.req1_ready, 0);
      @(negedge clk);
      check("req1 accepted after handshake", bus.req1_ready, 1);
      @(posedge clk); #1 bus.req1_valid = 1'b0;
      wait_rsp(1, rr);

      // Both ports valid continuously from reset
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      gq.delete();
      rsp1_seen = 1'b0;
      exp_cur0 = {24'h000002, 5'b00000, 1'b0};
      exp_cur1 = {24'hFFFFFF, 5'b00001, 1'b0};
      bus.req0_a = 24'h000001; bus.req0_b = 24'h000001; bus.req0_op = 3'd0;
      bus.req1_a = 24'hF0F0F0; bus.req1_b = 24'h0F0F0F; bus.req1_op = 3'd1;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      repeat (12) @(negedge clk);
      @(posedge clk); #1 bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      repeat (4) @(negedge clk);
`ifdef ALU_SHARE_RR_EN
      exp_g = '{0, 1, 0, 1};
`else
      exp_g = '{0, 0, 0, 0};
      check("rsp1_valid never rose", rsp1_seen, 0);
`endif
      check("tie grant count", gq.size(), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("tie grant %0d", i), (i < gq.size()) ? gq[i] : 9, exp_g[i]);

      // Reset while the request is in EXEC
      send(0, 24'h000005, 24'h000003, 3'd0, {24'h000008, 5'b00000, 1'b0}, c);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("abort rsp0_valid", bus.rsp0_valid, 0);
      check("abort rsp1_valid", bus.rsp1_valid, 0);
      check("abort rsp0_result", bus.rsp0_result, 0);
      check("abort alu_a", alu_a, 0);
      check("abort alu_b", alu_b, 0);
      check("abort alu_ctrl", alu_ctrl, 0);
      check("abort req0_ready", bus.req0_ready, 0);
      q0.delete();
      rsp0_seen = 1'b0;
      repeat (5) @(negedge clk);
      check("aborted response not delivered", rsp0_seen, 0);

      check("port0 queue drained", q0.size(), 0);
      check("port1 queue drained", q1.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
